// File: rtl/frac_lut6_cfg_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : frac_lut6_cfg_pkg
//  Purpose  : Shared types and constants for the frac_lut6 configuration
//             loader: tile geometry, input stream width and the loader FSM
//             state encoding.
//  Revision : 1.0 - initial release
// ============================================================================
package frac_lut6_cfg_pkg;

    localparam int CFG_NUM_BITS  = 64;
    localparam int CFG_IN_WIDTH  = 8;
    localparam int CFG_NUM_BYTES = CFG_NUM_BITS / CFG_IN_WIDTH;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SETUP = 3'd2,
        ST_PULSE = 3'd3,
        ST_HOLD  = 3'd4,
        ST_DONE  = 3'd5
    } cfg_state_e;

endpackage : frac_lut6_cfg_pkg
`default_nettype wire

// File: rtl/cfg_word_assembler.sv
`default_nettype none
// ============================================================================
//  Module   : cfg_word_assembler
//  Purpose  : Collects the configuration byte stream into one NUM_BITS-wide
//             word. Byte k bit j lands in word bit k*IN_WIDTH + j.
//  Ports    : clk, rst      - clock, synchronous active-high reset
//             clear         - empties the word and rewinds the byte counter
//             load_en       - a byte is offered on i_data this cycle
//             i_data        - configuration byte
//             full          - all bytes of the word have been captured
//             o_last        - the next accepted byte completes the word
//             o_word_next   - value the word register takes at the next edge
//  Revision : 1.0 - initial release
// ============================================================================
module cfg_word_assembler
    import frac_lut6_cfg_pkg::*;
#(
    parameter int NUM_BITS = CFG_NUM_BITS,
    parameter int IN_WIDTH = CFG_IN_WIDTH
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic                load_en,
    input  logic [IN_WIDTH-1:0] i_data,
    output logic                full,
    output logic                o_last,
    output logic [0:NUM_BITS-1] o_word_next
);

    localparam int c_num_bytes = NUM_BITS / IN_WIDTH;
    localparam int c_cnt_w     = $clog2(c_num_bytes) + 1;

    logic [c_cnt_w-1:0]  r_cnt;
    logic [0:NUM_BITS-1] r_word;
    logic [0:NUM_BITS-1] w_word_next;
    logic                w_accept;

    // A full word ignores further bytes so the counter never runs past its
    // terminal value.
    assign w_accept = load_en && !full;

    // Each byte slot is written only when the counter points at it; all other
    // bits hold. Constant indices keep the insert a plain mux per bit.
    for (genvar k = 0; k < c_num_bytes; k++) begin : g_byte
        for (genvar j = 0; j < IN_WIDTH; j++) begin : g_bit
            assign w_word_next[k*IN_WIDTH + j] =
                (w_accept && (r_cnt == c_cnt_w'(k))) ? i_data[j]
                                                      : r_word[k*IN_WIDTH + j];
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_cnt  <= '0;
            r_word <= '0;
        end else begin
            r_word <= w_word_next;
            if (w_accept) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign full        = (r_cnt == c_cnt_w'(c_num_bytes));
    assign o_last      = (r_cnt == c_cnt_w'(c_num_bytes - 1));
    assign o_word_next = w_word_next;

endmodule : cfg_word_assembler
`default_nettype wire

// File: rtl/frac_lut6_cfg_loader.sv
`default_nettype none
// ============================================================================
//  Module   : frac_lut6_cfg_loader
//  Purpose  : Loads a frac_lut6 truth table from a byte stream and writes it
//             into the tile's latch memory with a setup / word-line pulse /
//             hold sequence.
//  Ports    : prog_clk, reset - clock, synchronous active-high reset
//             start           - request a load (honoured in IDLE only)
//             in_data/in_valid/in_ready - byte stream handshake
//             bl, wl          - bit-line data and word-line enables
//             busy            - any state other than IDLE
//             done            - one-cycle pulse when the write completes
//             err             - sticky protocol-violation flag
//  Revision : 1.0 - initial release
// ============================================================================
module frac_lut6_cfg_loader
    import frac_lut6_cfg_pkg::*;
#(
    parameter int NUM_BITS     = CFG_NUM_BITS,
    parameter int IN_WIDTH     = CFG_IN_WIDTH,
    parameter int PULSE_CYCLES = 2
) (
    input  logic                prog_clk,
    input  logic                reset,
    input  logic                start,
    input  logic [IN_WIDTH-1:0] in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [0:NUM_BITS-1] bl,
    output logic [0:NUM_BITS-1] wl,
    output logic                busy,
    output logic                done,
    output logic                err
);

    localparam logic [3:0] c_pulse_last = 4'(PULSE_CYCLES - 1);

    cfg_state_e          r_state;
    cfg_state_e          w_state_next;
    logic [3:0]          r_pulse_cnt;

    logic [0:NUM_BITS-1] r_bl;
    logic [0:NUM_BITS-1] r_wl;
    logic                r_busy;
    logic                r_done;
    logic                r_err;

    logic [0:NUM_BITS-1] w_bl_d;
    logic [0:NUM_BITS-1] w_wl_d;
    logic                w_busy_d;
    logic                w_done_d;
    logic                w_err_d;

    logic                w_start_ok;
    logic                w_load_en;
    logic                w_full;
    logic                w_last;
    logic [0:NUM_BITS-1] w_word_next;

    assign w_start_ok = (r_state == ST_IDLE) && start;
    assign w_load_en  = (r_state == ST_LOAD) && in_valid;

    cfg_word_assembler #(
        .NUM_BITS (NUM_BITS),
        .IN_WIDTH (IN_WIDTH)
    ) u_asm (
        .clk         (prog_clk),
        .rst         (reset),
        .clear       (w_start_ok),
        .load_en     (w_load_en),
        .i_data      (in_data),
        .full        (w_full),
        .o_last      (w_last),
        .o_word_next (w_word_next)
    );

    // ---------------------------------------------------------------- state
    always_ff @(posedge prog_clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_state_next = ST_LOAD;
            ST_LOAD:  if (in_valid && w_last && !w_full) w_state_next = ST_SETUP;
            ST_SETUP: w_state_next = ST_PULSE;
            ST_PULSE: if (r_pulse_cnt == c_pulse_last) w_state_next = ST_HOLD;
            ST_HOLD:  w_state_next = ST_DONE;
            ST_DONE:  w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    // -------------------------------------------------------------- outputs
    // Registered outputs are decoded from the next state so that they line up
    // with the state they describe. bl takes the assembler's next word so the
    // byte accepted on the last LOAD cycle is already present in SETUP.
    always_comb begin
        in_ready = (r_state == ST_LOAD);
        w_bl_d   = '0;
        w_wl_d   = '0;
        w_busy_d = (w_state_next != ST_IDLE);
        w_done_d = (w_state_next == ST_DONE);
        w_err_d  = r_err;

        if ((w_state_next == ST_SETUP) || (w_state_next == ST_PULSE) ||
            (w_state_next == ST_HOLD)) begin
            w_bl_d = w_word_next;
        end
        if (w_state_next == ST_PULSE) begin
            w_wl_d = '1;
        end

        if (w_start_ok) begin
            w_err_d = 1'b0;
        end else if ((r_state == ST_IDLE) && in_valid) begin
            w_err_d = 1'b1;
        end else if ((r_state != ST_IDLE) && start) begin
            w_err_d = 1'b1;
        end
    end

    always_ff @(posedge prog_clk) begin
        if (reset) begin
            r_bl        <= '0;
            r_wl        <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_pulse_cnt <= '0;
        end else begin
            r_bl   <= w_bl_d;
            r_wl   <= w_wl_d;
            r_busy <= w_busy_d;
            r_done <= w_done_d;
            r_err  <= w_err_d;
            // Counts pulse cycles; stops at the terminal value and rewinds
            // as soon as PULSE is left.
            if ((r_state == ST_PULSE) && (r_pulse_cnt != c_pulse_last)) begin
                r_pulse_cnt <= r_pulse_cnt + 4'd1;
            end else begin
                r_pulse_cnt <= '0;
            end
        end
    end

    assign bl   = r_bl;
    assign wl   = r_wl;
    assign busy = r_busy;
    assign done = r_done;
    assign err  = r_err;

endmodule : frac_lut6_cfg_loader
`default_nettype wire
